// File: rtl/imem_bank.sv
// imem_bank: writable, synchronous-read instruction memory for the multicycle CPU.
// A loader port streams a program image in at run time, and the fetch port
// gives a one-cycle request/valid read. Fetches at or beyond the loaded
// program length return NOP_WORD and raise fetch_fault.
module imem_bank #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INIT_LEN = 0,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_trunc,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [DATA_W-1:0] rdata;
  logic              hit;
  logic              accept;
  logic              at_end;
  logic              fetch_take;
  logic              in_range;

  assign accept     = (state == LOAD) && load_valid;
  assign at_end     = &wptr;
  assign fetch_take = (state == RUN) && fetch_req;
  // Full 32-bit compare so PCs beyond DEPTH never alias onto low addresses.
  assign in_range   = fetch_pc < 32'(prog_len);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  // Next-state logic: a download ends on load_last or when the array is full.
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (load_start) state_nx = LOAD;
      LOAD:    if (accept && (load_last || at_end)) state_nx = DONE;
      DONE:    state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Loader handshake and status outputs decoded from the state.
  always_comb begin
    load_ready = (state == LOAD);
    load_done  = (state == DONE);
    busy       = (state != RUN);
  end

  // Write pointer, program length, truncation flag and fetch result status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr        <= '0;
      prog_len    <= (ADDR_W+1)'(INIT_LEN);
      load_trunc  <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      hit         <= 1'b0;
    end else begin
      fetch_valid <= fetch_take;
      if (fetch_take) begin
        fetch_fault <= !in_range;
        hit         <= in_range;
      end
      // prog_len clears at the same edge the fetch compares against the old
      // value, so a coincident fetch still sees the previous image.
      if ((state == RUN) && load_start) begin
        wptr       <= '0;
        prog_len   <= '0;
        load_trunc <= 1'b0;
      end
      if (accept) begin
        wptr <= wptr + ADDR_W'(1);
        if (load_last || at_end) prog_len <= {1'b0, wptr} + (ADDR_W+1)'(1);
        if (at_end && !load_last) load_trunc <= 1'b1;
      end
    end
  end

  // Memory array: loader writes and registered fetch reads, never reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= load_data;
    if (fetch_take && in_range) rdata <= mem[fetch_pc[ADDR_W-1:0]];
  end

  assign fetch_instr = hit ? rdata : NOP_WORD;

endmodule
